// File: rtl/sram_port_arbiter_pkg.sv
// ============================================================================
// Module   : sram_port_arbiter_pkg
// Purpose  : Shared state encodings, owner constants and defaults for the
//            SRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   localparam logic ARB_OWNER_IF  = 1'b0;
   localparam logic ARB_OWNER_MEM = 1'b1;

   localparam int ARB_DEFAULT_WAIT_CYCLES = 3;

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// Module   : sram_wait_counter
// Purpose  : Loadable down-counter that times one SRAM access; saturates at 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wait_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one fixed-latency SRAM between fetch and memory stage.
//            SRAM_ARB_ROUND_ROBIN_EN selects alternating priority on contention.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = ARB_DEFAULT_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        mem_rreq,
   input  logic        mem_wreq,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        sram_en,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        freeze
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

   arb_state_t state;
   arb_state_t state_next;

   logic        mem_pending;
   logic        any_req;
   logic        grant_owner;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;
   logic        capture;
   logic        grant;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        we_q;
   logic        owner_q;

   assign mem_pending = mem_rreq | mem_wreq;
   assign any_req     = if_req | mem_pending;
   assign grant       = (state == ARB_IDLE) && any_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_owner;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner <= ARB_OWNER_MEM;
      end else if (grant) begin
         last_owner <= grant_owner;
      end
   end

   // On contention the requester that did not own the previous access wins.
   always_comb begin
      grant_owner = ARB_OWNER_MEM;
      if (if_req && mem_pending) begin
         grant_owner = (last_owner == ARB_OWNER_MEM) ? ARB_OWNER_IF : ARB_OWNER_MEM;
      end else if (if_req) begin
         grant_owner = ARB_OWNER_IF;
      end
   end
`else
   assign grant_owner = mem_pending ? ARB_OWNER_MEM : ARB_OWNER_IF;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      capture    = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (any_req) begin
               cnt_load   = 1'b1;
               state_next = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (cnt_zero) begin
               capture    = 1'b1;
               state_next = ARB_DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ARB_DONE: begin
            state_next = ARB_IDLE;
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   sram_wait_counter #(
      .WIDTH (CW)
   ) u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // A simultaneous read and write request is performed as a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         owner_q <= ARB_OWNER_IF;
      end else if (grant) begin
         owner_q <= grant_owner;
         if (grant_owner == ARB_OWNER_MEM) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            we_q    <= mem_wreq;
         end else begin
            addr_q  <= if_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (capture && !we_q) begin
         rdata_q <= sram_rdata;
      end
   end

   assign sram_en    = (state == ARB_BUSY);
   assign sram_we    = (state == ARB_BUSY) && we_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

   assign if_ready   = (state == ARB_DONE) && (owner_q == ARB_OWNER_IF);
   assign mem_ready  = (state == ARB_DONE) && (owner_q == ARB_OWNER_MEM);
   assign if_rdata   = rdata_q;
   assign mem_rdata  = rdata_q;

   assign freeze = (if_req & ~if_ready) | (mem_pending & ~mem_ready);

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Directed self-checking bench for sram_port_arbiter (WAIT 3 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        mem_rreq = 1'b0;
   logic        mem_wreq = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        sram_en;
   logic        sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        freeze;

   logic        b_if_req = 1'b0;
   logic [31:0] b_if_addr = '0;
   logic        b_if_ready;
   logic [31:0] b_if_rdata;
   logic        b_mem_ready;
   logic [31:0] b_mem_rdata;
   logic        b_sram_en;
   logic        b_sram_we;
   logic [31:0] b_sram_addr;
   logic [31:0] b_sram_wdata;
   logic [31:0] b_sram_rdata;
   logic        b_freeze;

   int total = 0;
   int bad   = 0;

   logic        en_log    [0:15];
   logic        we_log    [0:15];
   logic [31:0] addr_log  [0:15];
   logic [31:0] wdata_log [0:15];
   logic        frz_log   [0:15];
   int          if_cyc;
   int          mem_cyc;
   logic [31:0] if_dat;
   logic [31:0] mem_dat;

   always #5 clk = ~clk;

   function automatic logic [31:0] sram_model(input logic [31:0] a);
      return (a == 32'h0000_0100) ? 32'hE3A0_1005 : (a ^ 32'hA5A5_0000);
   endfunction

   assign sram_rdata   = sram_model(sram_addr);
   assign b_sram_rdata = sram_model(b_sram_addr);

   sram_port_arbiter #(.WAIT_CYCLES(3)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_ready   (if_ready),
      .if_rdata   (if_rdata),
      .mem_rreq   (mem_rreq),
      .mem_wreq   (mem_wreq),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .freeze     (freeze)
   );

   sram_port_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
      .clk        (clk),
      .rst        (rst),
      .if_req     (b_if_req),
      .if_addr    (b_if_addr),
      .if_ready   (b_if_ready),
      .if_rdata   (b_if_rdata),
      .mem_rreq   (1'b0),
      .mem_wreq   (1'b0),
      .mem_addr   (32'h0),
      .mem_wdata  (32'h0),
      .mem_ready  (b_mem_ready),
      .mem_rdata  (b_mem_rdata),
      .sram_en    (b_sram_en),
      .sram_we    (b_sram_we),
      .sram_addr  (b_sram_addr),
      .sram_wdata (b_sram_wdata),
      .sram_rdata (b_sram_rdata),
      .freeze     (b_freeze)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Cycle 0 is the negedge on which the caller raised the requests.
   task automatic run_access(input int max_c);
      if_cyc  = -1;
      mem_cyc = -1;
      for (int c = 0; c <= max_c; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         en_log[c]    = sram_en;
         we_log[c]    = sram_we;
         addr_log[c]  = sram_addr;
         wdata_log[c] = sram_wdata;
         frz_log[c]   = freeze;
         if (if_ready && if_cyc < 0) begin
            if_cyc = c;
            if_dat = if_rdata;
            if_req = 1'b0;
         end
         if (mem_ready && mem_cyc < 0) begin
            mem_cyc  = c;
            mem_dat  = mem_rdata;
            mem_rreq = 1'b0;
            mem_wreq = 1'b0;
         end
      end
   endtask

   initial begin
      int b_rdy;
      int b_en_cnt;

      repeat (2) @(negedge clk);
      check("rst_sram_en", 32'(sram_en), 32'd0);
      check("rst_sram_addr", sram_addr, 32'h0);
      check("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      check("rst_rdata", if_rdata | mem_rdata, 32'h0);
      rst = 1'b0;

      // Fetch read with per-cycle freeze
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      run_access(6);
      check("fetch_ready_cycle", 32'(if_cyc), 32'd4);
      check("fetch_rdata", if_dat, 32'hE3A0_1005);
      check("fetch_no_mem_ready", 32'(mem_cyc), 32'hFFFF_FFFF);
      check("fetch_freeze_c0_3", {28'd0, frz_log[0], frz_log[1], frz_log[2], frz_log[3]}, 32'hF);
      check("fetch_freeze_c4", 32'(frz_log[4]), 32'd0);
      check("fetch_en_c0_4", {27'd0, en_log[0], en_log[1], en_log[2], en_log[3], en_log[4]}, 32'b01110);

      // Memory write
      @(negedge clk);
      mem_wreq  = 1'b1;
      mem_addr  = 32'h0000_0400;
      mem_wdata = 32'hDEAD_BEEF;
      run_access(6);
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("wr_en_we_c%0d", c), {30'd0, en_log[c], we_log[c]}, 32'b11);
         check($sformatf("wr_addr_c%0d", c), addr_log[c], 32'h0000_0400);
         check($sformatf("wr_wdata_c%0d", c), wdata_log[c], 32'hDEAD_BEEF);
      end
      check("wr_mem_ready_cycle", 32'(mem_cyc), 32'd4);
      check("wr_no_if_ready", 32'(if_cyc), 32'hFFFF_FFFF);

      // Contention: previous owner was the memory stage
      @(negedge clk);
      if_req   = 1'b1;
      if_addr  = 32'h0000_0104;
      mem_rreq = 1'b1;
      mem_addr = 32'h0000_0200;
      run_access(12);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      check("rr_if_cycle", 32'(if_cyc), 32'd4);
      check("rr_mem_cycle", 32'(mem_cyc), 32'd9);
`else
      check("prio_mem_cycle", 32'(mem_cyc), 32'd4);
      check("prio_if_cycle", 32'(if_cyc), 32'd9);
`endif
      check("cont_mem_rdata", mem_dat, 32'hA5A5_0200);
      check("cont_if_rdata", if_dat, 32'hA5A5_0104);

      // Read and write together perform a write
      @(negedge clk);
      mem_rreq  = 1'b1;
      mem_wreq  = 1'b1;
      mem_addr  = 32'h0000_0480;
      mem_wdata = 32'h1234_5678;
      run_access(6);
      check("rw_we_c1", {30'd0, en_log[1], we_log[1]}, 32'b11);
      check("rw_wdata_c2", wdata_log[2], 32'h1234_5678);
      check("rw_ready_cycle", 32'(mem_cyc), 32'd4);

      // Fetch address moves during BUSY
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_0300;
      @(negedge clk);
      #1;
      if_addr = 32'h0000_03FC;
      @(negedge clk);
      #1;
      check("addr_hold_c2", sram_addr, 32'h0000_0300);
      @(negedge clk);
      #1;
      check("addr_hold_c3", sram_addr, 32'h0000_0300);
      @(negedge clk);
      #1;
      check("addr_hold_ready", 32'(if_ready), 32'd1);
      check("addr_hold_rdata", if_rdata, 32'hA5A5_0300);
      if_req = 1'b0;

      // Reset in the middle of a write
      @(negedge clk);
      mem_wreq  = 1'b1;
      mem_wreq  = 1'b1;
      mem_addr  = 32'h0000_0040;
      mem_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("mid_rst_busy", {30'd0, sram_en, sram_we}, 32'b11);
      rst      = 1'b1;
      mem_wreq = 1'b0;
      @(negedge clk);
      #1;
      check("mid_rst_sram", {30'd0, sram_en, sram_we}, 32'd0);
      check("mid_rst_addr", sram_addr | sram_wdata, 32'h0);
      check("mid_rst_ready_frz", {29'd0, if_ready, mem_ready, freeze}, 32'd0);
      check("mid_rst_rdata", if_rdata | mem_rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      run_access(6);
      check("post_rst_if_cycle", 32'(if_cyc), 32'd4);
      check("post_rst_if_rdata", if_dat, 32'hE3A0_1005);

      // Single-cycle access length
      @(negedge clk);
      b_if_req  = 1'b1;
      b_if_addr = 32'h0000_0100;
      b_rdy     = -1;
      b_en_cnt  = 0;
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (b_sram_en) b_en_cnt++;
         if (b_if_ready && b_rdy < 0) begin
            b_rdy = c;
            check("w1_rdata", b_if_rdata, 32'hE3A0_1005);
            b_if_req = 1'b0;
         end
      end
      check("w1_ready_cycle", 32'(b_rdy), 32'd2);
      check("w1_busy_cycles", 32'(b_en_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
